// File: rtl/sub_bytes_pipe.sv
// sub_bytes_pipe: two-stage banked AES SubBytes engine with valid/ready flow control.
// Define SBOX_INV_EN to build the inverse S-box and honour in_inv per transaction.
module sub_bytes_pipe #(
  parameter int LANES = 4,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_inv,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               out_inv,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);
`ifdef SBOX_INV_EN
  localparam logic INV_EN = 1'b1;
`else
  localparam logic INV_EN = 1'b0;
`endif

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = x[7] ? {x[6:0], 1'b0} ^ 8'h1b : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); zero maps to zero
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

`ifdef SBOX_INV_EN
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction
`endif

  logic                           v1_q, v1_d, v2_q, v2_d;
  logic                           inv1_q, inv1_d, inv2_q, inv2_d;
  logic [TAG_W-1:0]               tag1_q, tag1_d, tag2_q, tag2_d;
  logic [LANES-1:0][7:0][7:0]     bank_q, bank_d;
  logic [8*LANES-1:0]             data2_q, data2_d;
  logic                           ld1, ld2;
  logic [7:0]                     x, sub, acc;

  assign ld2       = !v2_q || out_ready;
  assign ld1       = !v1_q || ld2;
  assign in_ready  = ld1 && !rst;
  assign out_valid = v2_q;
  assign out_data  = data2_q;
  assign out_inv   = inv2_q;
  assign out_tag   = tag2_q;
  assign busy      = v1_q || v2_q;

  always_comb begin
    x       = '0;
    sub     = '0;
    acc     = '0;
    v1_d    = ld1 ? in_valid : v1_q;
    inv1_d  = ld1 ? in_inv & INV_EN : inv1_q;
    tag1_d  = ld1 ? in_tag : tag1_q;
    bank_d  = bank_q;
    v2_d    = ld2 ? v1_q : v2_q;
    inv2_d  = ld2 ? inv1_q : inv2_q;
    tag2_d  = ld2 ? tag1_q : tag2_q;
    data2_d = data2_q;
    for (int l = 0; l < LANES; l++) begin
      x = in_data[8*l +: 8];
`ifdef SBOX_INV_EN
      sub = in_inv ? inv_sbox(x) : fwd_sbox(x);
`else
      sub = fwd_sbox(x);
`endif
      // bank = {row group, column half}; only the addressed bank carries the byte
      for (int b = 0; b < 8; b++)
        bank_d[l][b] = ld1 ? ((3'(b) == {x[7:6], x[3]}) ? sub : 8'h00) : bank_q[l][b];
      acc = '0;
      for (int b = 0; b < 8; b++)
        acc = acc ^ bank_q[l][b];
      data2_d[8*l +: 8] = ld2 ? acc : data2_q[8*l +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      inv1_q  <= 1'b0;
      inv2_q  <= 1'b0;
      tag1_q  <= '0;
      tag2_q  <= '0;
      bank_q  <= '0;
      data2_q <= '0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      inv1_q  <= inv1_d;
      inv2_q  <= inv2_d;
      tag1_q  <= tag1_d;
      tag2_q  <= tag2_d;
      bank_q  <= bank_d;
      data2_q <= data2_d;
    end
  end
endmodule
